// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: sequencing controller for a multi-cycle MUL/DIV/REM unit
// that sits beside the ALU in the EX stage. It latches a MULDIV instruction's
// operands, launches the unit with a start pulse, stalls the pipeline while
// the unit works, and hands the result back to the EX result mux for one
// cycle. A flush either cancels the operation outright or, once the unit is
// already busy, drains the orphaned result.
//
// Optional build macro: MULDIV_TIMEOUT_EN adds a watchdog that aborts a WAIT
// or DRAIN lasting TIMEOUT_CYCLES cycles and pulses timeout_o.
module ex_muldiv_ctrl #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_REG_SIZE = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OPCODE_SIZE    = 7,
  parameter int FUNCT7_SIZE    = 7,
  parameter int FUNCT3_SIZE    = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_i,
  input  logic [OPCODE_SIZE-1:0]    opcode_i,
  input  logic [FUNCT7_SIZE-1:0]    funct7_i,
  input  logic [FUNCT3_SIZE-1:0]    funct3_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  input  logic [WD_SIZE-1:0]        rs1_data_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic                      flush_i,
  output logic                      mul_start_o,
  output logic [WD_SIZE-1:0]        mul_op1_o,
  output logic [WD_SIZE-1:0]        mul_op2_o,
  output logic [FUNCT3_SIZE-1:0]    mul_funct3_o,
  input  logic                      mul_done_i,
  input  logic [WD_SIZE-1:0]        mul_result_i,
  output logic                      stall_proc_o,
  output logic                      result_valid_o,
  output logic [WD_SIZE-1:0]        result_o,
  output logic [INSTR_REG_SIZE-1:0] rd_o,
  output logic                      ctrl_reg_write_o,
  output logic                      timeout_o
);

  localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = OPCODE_SIZE'(7'b0110011);
  localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = FUNCT7_SIZE'(7'b0000001);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Elaboration-time sanity check on the watchdog limit.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]                state_q,  state_d;
  logic [WD_SIZE-1:0]        op1_q,    op1_d;
  logic [WD_SIZE-1:0]        op2_q,    op2_d;
  logic [FUNCT3_SIZE-1:0]    funct3_q, funct3_d;
  logic [INSTR_REG_SIZE-1:0] rd_q,     rd_d;
  logic [WD_SIZE-1:0]        result_q, result_d;
  logic                      accept;
  logic                      timeout_hit;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // A MULDIV instruction is only taken while the controller is idle.
  assign accept = (state_q == S_IDLE) && valid_i && !flush_i &&
                  (opcode_i == OPCODE_OP) && (funct7_i == F7_MULDIV);

  // Watchdog: counts cycles spent in WAIT/DRAIN, cleared on every entry.
`ifdef MULDIV_TIMEOUT_EN
  always_comb begin
    timeout_hit = 1'b0;
    if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !mul_done_i &&
        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)))
      timeout_hit = 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and capture logic for the sequencing FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op1_d    = rs1_data_i;
          op2_d    = rs2_data_i;
          funct3_d = funct3_i;
          rd_d     = rd_i;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = flush_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (mul_done_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            result_d = mul_result_i;
            state_d  = S_DONE;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mul_done_i || timeout_hit) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MULDIV_TIMEOUT_EN
  // Counter runs only while staying in WAIT or DRAIN; any transition clears it.
  always_comb begin
    cnt_d = '0;
    if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && (state_d == state_q))
      cnt_d = cnt_q + CNT_W'(1);
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the operand/result registers are reset too, since they drive outputs that must read 0 after reset.
      state_q  <= S_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Outputs: pulses decode the state, gated by flush where a flush cancels them.
  assign mul_start_o      = (state_q == S_START) && !flush_i;
  assign stall_proc_o     = accept || (state_q == S_START) ||
                            (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign result_valid_o   = (state_q == S_DONE) && !flush_i;
  assign ctrl_reg_write_o = result_valid_o && (rd_q != '0);
  assign timeout_o        = timeout_hit;
  assign mul_op1_o        = op1_q;
  assign mul_op2_o        = op2_q;
  assign mul_funct3_o     = funct3_q;
  assign result_o         = result_q;
  assign rd_o             = rd_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: self-checking bench for ex_muldiv_ctrl. The bench plays
// the role of the MUL/DIV unit, pushes the expected result of every operation
// that must complete into a scoreboard, and a monitor pops it when the
// controller raises result_valid_o.
module tb_ex_muldiv_ctrl;

  localparam logic [6:0] OP_OP  = 7'b0110011;
  localparam logic [6:0] F7_MD  = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [6:0]  opcode_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        mul_start_o;
  logic [31:0] mul_op1_o, mul_op2_o;
  logic [2:0]  mul_funct3_o;
  logic        mul_done_i = 1'b0;
  logic [31:0] mul_result_i = '0;
  logic        stall_proc_o, result_valid_o, ctrl_reg_write_o, timeout_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_muldiv_ctrl #(
    .WD_SIZE(32), .INSTR_REG_SIZE(5), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .opcode_i(opcode_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .mul_start_o(mul_start_o), .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_funct3_o(mul_funct3_o), .mul_done_i(mul_done_i),
    .mul_result_i(mul_result_i), .stall_proc_o(stall_proc_o),
    .result_valid_o(result_valid_o), .result_o(result_o), .rd_o(rd_o),
    .ctrl_reg_write_o(ctrl_reg_write_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_muldiv(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f3, input logic [4:0] rd);
    valid_i    = 1'b1;
    opcode_i   = OP_OP;
    funct7_i   = F7_MD;
    funct3_i   = f3;
    rd_i       = rd;
    rs1_data_i = a;
    rs2_data_i = b;
  endtask

  task automatic idle_inputs();
    valid_i    = 1'b0;
    opcode_i   = '0;
    funct7_i   = '0;
    rs1_data_i = 32'hDEAD_BEEF;
    rs2_data_i = 32'hCAFE_F00D;
  endtask

  // Full operation: accept at T, start at T+1, done at T+1+lat, valid at T+2+lat.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic [4:0] rd, input int lat, input logic [31:0] res);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.wr  = (rd != 5'd0);
    drive_muldiv(a, b, f3, rd);
    sb_q.push_back(e);
    #3;
    check("accept_stall", stall_proc_o, 1'b1);
    check("accept_no_start", mul_start_o, 1'b0);
    tick();
    idle_inputs();
    #3;
    check("start_pulse", mul_start_o, 1'b1);
    check("start_stall", stall_proc_o, 1'b1);
    check("op1_latch", mul_op1_o, a);
    check("op2_latch", mul_op2_o, b);
    check("funct3_latch", mul_funct3_o, f3);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i == lat) begin
        mul_done_i   = 1'b1;
        mul_result_i = res;
      end
      #3;
      check("wait_no_start", mul_start_o, 1'b0);
      check("wait_stall", stall_proc_o, 1'b1);
      check("wait_no_timeout", timeout_o, 1'b0);
    end
    tick();
    mul_done_i   = 1'b0;
    mul_result_i = 32'h5A5A_5A5A;
    #3;
    check("done_stall_low", stall_proc_o, 1'b0);
    check("done_valid", result_valid_o, 1'b1);
    tick();
    #3;
    check("after_valid_low", result_valid_o, 1'b0);
    check("result_hold", result_o, res);
    check("rd_hold", rd_o, rd);
  endtask

  // Scoreboard monitor: every result_valid_o must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!result_valid_o) check("write_without_valid", ctrl_reg_write_o, 1'b0);
      if (result_valid_o) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", result_valid_o, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result", result_o, mon_e.res);
          check("sb_rd", rd_o, mon_e.rd);
          check("sb_reg_write", ctrl_reg_write_o, mon_e.wr);
        end
      end
    end
  end

  initial begin
    int k;
    // Reset state.
    #12;
    check("rst_stall", stall_proc_o, 1'b0);
    check("rst_start", mul_start_o, 1'b0);
    check("rst_valid", result_valid_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_rd", rd_o, 5'h0);
    check("rst_op1", mul_op1_o, 32'h0);
    check("rst_timeout", timeout_o, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic MUL, then rd=0 (no register write).
    do_op(32'd7, 32'd6, 3'b000, 5'd5, 3, 32'd42);
    do_op(32'hFFFF_FFFF, 32'd1, 3'b000, 5'd0, 2, 32'hFFFF_FFFF);

    // ADD (funct7=0) and a flushed MULDIV are both ignored.
    valid_i = 1'b1; opcode_i = OP_OP; funct7_i = 7'b0000000; rd_i = 5'd3;
    #3;
    check("add_stall", stall_proc_o, 1'b0);
    tick();
    #3;
    check("add_no_start", mul_start_o, 1'b0);
    tick();
    drive_muldiv(32'd2, 32'd2, 3'b000, 5'd4);
    flush_i = 1'b1;
    #3;
    check("flushed_accept_stall", stall_proc_o, 1'b0);
    tick();
    idle_inputs();
    flush_i = 1'b0;
    #3;
    check("flushed_accept_no_start", mul_start_o, 1'b0);
    check("flushed_accept_idle", stall_proc_o, 1'b0);
    tick();

    // Flush in WAIT: DRAIN absorbs the late result, nothing is written back.
    drive_muldiv(32'd7, 32'd6, 3'b000, 5'd5);
    tick(); idle_inputs();
    tick(); flush_i = 1'b1;
    #3; check("flush_wait_stall", stall_proc_o, 1'b1);
    tick(); flush_i = 1'b0;
    #3; check("drain_stall", stall_proc_o, 1'b1);
    tick(); mul_done_i = 1'b1; mul_result_i = 32'd42;
    #3; check("drain_done_stall", stall_proc_o, 1'b1);
    tick(); mul_done_i = 1'b0;
    #3;
    check("drain_exit_stall", stall_proc_o, 1'b0);
    check("drain_no_capture", result_o, 32'hFFFF_FFFF);
    tick();
    do_op(32'd3, 32'd3, 3'b000, 5'd7, 1, 32'd9);

    // Flush in START: the unit is never launched.
    drive_muldiv(32'd5, 32'd5, 3'b000, 5'd8);
    tick(); idle_inputs(); flush_i = 1'b1;
    #3;
    check("flush_start_no_pulse", mul_start_o, 1'b0);
    check("flush_start_stall", stall_proc_o, 1'b1);
    tick(); flush_i = 1'b0;
    #3;
    check("flush_start_stall_drop", stall_proc_o, 1'b0);
    check("flush_start_still_no_pulse", mul_start_o, 1'b0);

    // Done pulse while idle is ignored.
    mul_done_i = 1'b1; mul_result_i = 32'h1111_1111;
    tick(); mul_done_i = 1'b0;
    #3;
    check("idle_done_stall", stall_proc_o, 1'b0);
    check("idle_done_no_capture", result_o, 32'd9);
    tick();

    // Flush and done in the same WAIT cycle: result discarded.
    drive_muldiv(32'd4, 32'd4, 3'b000, 5'd6);
    tick(); idle_inputs();
    tick(); flush_i = 1'b1; mul_done_i = 1'b1; mul_result_i = 32'd16;
    tick(); flush_i = 1'b0; mul_done_i = 1'b0;
    #3;
    check("flush_done_idle", stall_proc_o, 1'b0);
    check("flush_done_no_capture", result_o, 32'd9);
    tick();

    // Flush in DONE: valid and write suppressed.
    drive_muldiv(32'd8, 32'd2, 3'b000, 5'd9);
    tick(); idle_inputs();
    tick(); mul_done_i = 1'b1; mul_result_i = 32'd16;
    tick(); mul_done_i = 1'b0; flush_i = 1'b1;
    #3;
    check("flush_done_state_valid", result_valid_o, 1'b0);
    check("flush_done_state_write", ctrl_reg_write_o, 1'b0);
    check("flush_done_state_stall", stall_proc_o, 1'b0);
    tick(); flush_i = 1'b0;
    #3;
    check("after_flush_done_stall", stall_proc_o, 1'b0);
    tick();

    // DIV with a different funct3.
    do_op(32'd100, 32'd7, 3'b100, 5'd9, 4, 32'd14);

`ifdef MULDIV_TIMEOUT_EN
    // Watchdog: no done ever arrives; timeout on the 8th WAIT cycle.
    drive_muldiv(32'd1, 32'd1, 3'b000, 5'd2);
    tick(); idle_inputs();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      #3;
      if (timeout_o) begin
        k = i;
        break;
      end
    end
    check("timeout_cycle", k, 8);
    tick();
    #3;
    check("timeout_stall_low", stall_proc_o, 1'b0);
    check("timeout_pulse_once", timeout_o, 1'b0);
    tick();
`else
    // Without the watchdog a long wait simply completes.
    k = 0;
    do_op(32'd12, 32'd12, 3'b000, 5'd10, 20, 32'd144);
`endif

    // Reset in WAIT abandons the operation; the late done is ignored.
    drive_muldiv(32'd9, 32'd9, 3'b000, 5'd11);
    tick(); idle_inputs();
    tick();
    #2; reset_n = 1'b0;
    #1;
    check("midrst_stall", stall_proc_o, 1'b0);
    check("midrst_result", result_o, 32'h0);
    check("midrst_op1", mul_op1_o, 32'h0);
    check("midrst_rd", rd_o, 5'h0);
    tick(); reset_n = 1'b1;
    tick(); mul_done_i = 1'b1; mul_result_i = 32'd81;
    tick(); mul_done_i = 1'b0;
    #3;
    check("post_rst_stall", stall_proc_o, 1'b0);
    check("post_rst_no_capture", result_o, 32'h0);
    tick(); tick();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Sequencing controller for a multi-cycle M-extension unit (MUL/DIV/REM) beside the ALU in the EX stage.
- Detects MULDIV instructions in EX and latches their operands and destination.
- Launches the external unit with a one-cycle start pulse and holds stall_proc_o high until the result returns.
- Presents the result with rd and a write-enable for one cycle to the EX result mux.
- Handles pipeline flush, including draining an orphaned operation.

Parameters:
WD_SIZE, 32, datapath width
INSTR_REG_SIZE, 5, register index width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MULDIV_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
valid_i  in  1  instruction in EX is valid this cycle
opcode_i  in  OPCODE_SIZE  decoded opcode
funct7_i  in  FUNCT7_SIZE  decoded funct7
funct3_i  in  FUNCT3_SIZE  operation select
rd_i  in  INSTR_REG_SIZE  destination register
rs1_data_i  in  WD_SIZE  operand 1
rs2_data_i  in  WD_SIZE  operand 2
flush_i  in  1  kill the in-flight instruction
mul_start_o  out  1  one-cycle launch pulse to the unit
mul_op1_o  out  WD_SIZE  latched operand 1
mul_op2_o  out  WD_SIZE  latched operand 2
mul_funct3_o  out  FUNCT3_SIZE  latched operation
mul_done_i  in  1  unit result valid, one-cycle pulse
mul_result_i  in  WD_SIZE  unit result
stall_proc_o  out  1  freeze upstream stages
result_valid_o  out  1  result valid pulse
result_o  WD_SIZE  out  captured result
rd_o  out  INSTR_REG_SIZE  captured destination register
ctrl_reg_write_o  out  1  register-file write enable
timeout_o  out  1  watchdog abort pulse

Behaviour:
- Accept condition, evaluated in IDLE only: valid_i & ~flush_i & opcode_i==OPCODE_OP (7'b0110011) & funct7_i==F7_MULDIV (7'b0000001).
- Reset (asynchronous, reset_n=0): state=IDLE and every output 0, including the mul_op*/result_o/rd_o registers. A reset mid-operation abandons the operation; a later mul_done_i is ignored while in IDLE.
- States:
  - IDLE: on accept, latch rs1/rs2/funct3/rd, then go to START.
  - START: mul_start_o=1 for exactly one cycle, then go to WAIT.
  - WAIT: on mul_done_i, capture mul_result_i into result_o, then go to DONE.
  - DONE: result_valid_o=1 for one cycle; ctrl_reg_write_o=1 only if rd!=0; then go to IDLE.
  - DRAIN: wait for mul_done_i, discard the result, then go to IDLE; no result and no write.
- stall_proc_o is combinational: high in the accept cycle, START, WAIT and DRAIN; low in IDLE without accept and in DONE. Upstream therefore advances in the DONE cycle.
- Latency: accept at cycle T, start at T+1. Unit done at T+1+L gives result_valid at T+2+L. Stall is high from T through T+1+L.
- Flush handling:
  - START: go to IDLE; the unit is never launched.
  - WAIT with mul_done_i low: go to DRAIN.
  - WAIT with mul_done_i high in the same cycle: go to IDLE, result discarded.
  - DONE: suppress result_valid_o and ctrl_reg_write_o; go to IDLE.
- mul_done_i in IDLE, START or DONE is ignored.
- Non-MULDIV instructions never affect this block.
- Outputs mul_op*, mul_funct3_o, rd_o and result_o hold their value until the next capture.

Optional Feature:
MULDIV_TIMEOUT_EN
- Defined: a cycle counter clears on entry to WAIT or DRAIN and increments each cycle in those states. When it reaches TIMEOUT_CYCLES without mul_done_i, the block pulses timeout_o for one cycle and returns to IDLE with no result_valid_o and no write. The counter is cleared by reset.
- Undefined: no counter is built, timeout_o is tied 0, and WAIT/DRAIN wait indefinitely.

Test Plan:
- MUL: rs1=7, rs2=6, rd=5, unit done 3 cycles after start with result 42 -> start pulse at T+1; result_valid with result_o=42, rd_o=5, reg_write=1 at T+5; stall high T..T+4.
- MUL with rd=0, result 0xFFFF_FFFF -> result_valid=1, ctrl_reg_write_o=0.
- flush_i asserted in WAIT, done 2 cycles later -> DRAIN entered; no result_valid. A new MUL (3*3) accepted afterwards returns 9, with no stale 42.
- flush_i in START -> mul_start_o never pulses; stall drops the next cycle.
- ADD (funct7=0) with valid_i=1 -> no start, stall stays 0.
- MULDIV_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no done -> timeout_o pulses after 8 WAIT cycles; state returns to IDLE; stall=0.
